// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Writable instruction memory with a byte-stream boot loader. It replaces the
// fixed-contents instruction ROM. The CPU fetch side is unchanged: a
// combinational Read_Address -> instruction lookup. The write side accepts a
// framed program over a byte handshake and writes it into an internal
// 8-bit-wide RAM.
//
// Frame on the byte stream:
//   byte 0        N, the number of instruction bytes (0..255, N <= DEPTH)
//   bytes 1..N    instructions, written to addresses 0..N-1 in order
//   byte N+1      checksum = sum of the N instruction bytes mod 256
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1. in_ready depends only on FSM state, never on in_valid, so the
// sender may hold or drop in_valid freely between bytes.
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   in_valid      in_data carries a stream byte
//   in_ready      loader accepts a byte this cycle (LEN/DATA/CHECK)
//   in_data       stream byte
//   Read_Address  CPU fetch address
//   instruction   mem[Read_Address], combinational; 0 outside DEPTH
//   busy          load in progress; the top level holds the PC on it
//   done          last load finished with a good checksum (sticky)
//   error         last load failed its checksum (sticky)
//   word_count    instruction bytes written in the current or last load
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic [ADDR_W-1:0] Read_Address,
   output logic [7:0]        instruction,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        word_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   logic [2:0]        state;
   logic [7:0]        len_q;
   logic [7:0]        sum_q;
   logic              loading;
   logic              xfer;
   logic [7:0]        wc_next;
   logic [ADDR_W-1:0] wr_addr;

   // Contents are deliberately not reset: they survive a reset so a
   // half-loaded program remains visible, and RAM needs no reset network.
   logic [7:0] mem [DEPTH];

   assign loading  = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
   assign in_ready = loading;
   assign busy     = loading;
   assign done     = (state == S_DONE);
   assign error    = (state == S_ERR);
   assign xfer     = in_valid && in_ready;
   assign wc_next  = word_count + 8'd1;
   assign wr_addr  = ADDR_W'(word_count);

   // Loader FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         len_q      <= 8'd0;
         sum_q      <= 8'd0;
         word_count <= 8'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state      <= S_LEN;
                  word_count <= 8'd0;
                  sum_q      <= 8'd0;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  len_q <= in_data;
                  // An empty program goes straight to its checksum byte.
                  state <= (in_data == 8'd0) ? S_CHECK : S_DATA;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  sum_q      <= sum_q + in_data;
                  word_count <= wc_next;
                  if (wc_next == len_q) state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (xfer) state <= (in_data == sum_q) ? S_DONE : S_ERR;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write port: one instruction byte per accepted DATA transfer, at the
   // address given by the count of bytes already written.
   always_ff @(posedge clk) begin
      if ((state == S_DATA) && xfer) mem[wr_addr] <= in_data;
   end

   // Read port: combinational, available in every state. The range check is
   // only elaborated when the address space is larger than the memory.
   generate
      if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
         assign instruction = mem[Read_Address];
      end else begin : g_part_range
         assign instruction = ({1'b0, Read_Address} < (ADDR_W + 1)'(DEPTH))
                              ? mem[Read_Address] : 8'h00;
      end
   endgenerate

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled at that same point, well away from the
// next edge. Expected values are hand-computed from the frame definition
// (checksum = sum of instruction bytes mod 256).
//
// Note on the 5-byte frame 49 C1 18 A9 4D: 73+193+24+169+77 = 536, and
// 536 mod 256 = 24 = 8'h18, so 8'h18 is the good checksum; 8'hD0 and 8'hD1
// both fail the check and are used as bad-checksum frames.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] Read_Address;
   logic [7:0] instruction;
   logic       busy;
   logic       done;
   logic       error;
   logic [7:0] word_count;

   int checks      = 0;
   int failures    = 0;
   int busy_cycles = 0;

   logic [7:0] frame_a [5] = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D};
   logic [7:0] frame_d [3] = '{8'h11, 8'h22, 8'h33};

   imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .Read_Address (Read_Address),
      .instruction  (instruction),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .word_count   (word_count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] observed,
                        input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic check_mem(input string tag, input logic [7:0] addr,
                            input logic [7:0] expected);
      Read_Address = addr;
      #1;
      check(tag, instruction, expected);
   endtask

   // ---------------- drivers ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy === 1'b1) busy_cycles++;
   endtask

   // One transfer at full throughput: in_ready is high in every loading
   // state, so the byte is taken on the next edge.
   task automatic xfer(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (busy === 1'b1) busy_cycles++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      in_valid     = 1'b0;
      in_data      = 8'h00;
      Read_Address = 8'h00;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_in_ready", {7'd0, in_ready}, 8'd0);
      check("rst_busy",     {7'd0, busy},     8'd0);
      check("rst_done",     {7'd0, done},     8'd0);
      check("rst_error",    {7'd0, error},    8'd0);
      check("rst_wc",       word_count,       8'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Bytes offered while idle are refused
      in_valid = 1'b1; in_data = 8'h05;
      #1;
      check("idle_in_ready", {7'd0, in_ready}, 8'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("idle_still_idle", {7'd0, busy}, 8'd0);

      // Frame A: N=5, good checksum 8'h18, full throughput
      busy_cycles = 0;
      pulse_start();
      check("a_start_ready", {7'd0, in_ready}, 8'd1);
      xfer(8'd5);
      for (int i = 0; i < 5; i++) xfer(frame_a[i]);
      check("a_wc_before_chk", word_count, 8'd5);
      check("a_not_done_yet", {7'd0, done}, 8'd0);
      xfer(8'h18);
      check("a_done",  {7'd0, done},  8'd1);
      check("a_error", {7'd0, error}, 8'd0);
      check("a_busy",  {7'd0, busy},  8'd0);
      check("a_wc",    word_count,    8'd5);
      check("a_busy_cycles", 8'(busy_cycles), 8'd7);
      for (int i = 0; i < 5; i++)
         check_mem($sformatf("a_mem%0d", i), 8'(i), frame_a[i]);

      // DONE ignores offered bytes and stays sticky
      in_valid = 1'b1; in_data = 8'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("a_done_sticky", {7'd0, done}, 8'd1);
      check("a_done_no_ready", {7'd0, in_ready}, 8'd0);

      // Frame B: same frame, bad checksum 8'hD1
      pulse_start();
      check("b_start_clears_done", {7'd0, done}, 8'd0);
      check("b_start_clears_wc", word_count, 8'd0);
      xfer(8'd5);
      for (int i = 0; i < 5; i++) xfer(frame_a[i]);
      xfer(8'hD1);
      check("b_error", {7'd0, error}, 8'd1);
      check("b_done",  {7'd0, done},  8'd0);
      check("b_wc",    word_count,    8'd5);
      for (int i = 0; i < 5; i++)
         check_mem($sformatf("b_mem%0d", i), 8'(i), frame_a[i]);

      // Frame C: N=0, checksum 8'h00, no writes
      pulse_start();
      check("c_clears_error", {7'd0, error}, 8'd0);
      xfer(8'd0);
      check("c_in_check_busy", {7'd0, busy}, 8'd1);
      check("c_not_done", {7'd0, done}, 8'd0);
      xfer(8'h00);
      check("c_done", {7'd0, done}, 8'd1);
      check("c_wc",   word_count,   8'd0);
      check_mem("c_mem0_kept", 8'd0, 8'h49);

      // Frame D: N=3, gaps on in_valid, stray start mid-DATA
      pulse_start();
      idle_cycles($urandom_range(0, 2));
      xfer(8'd3);
      idle_cycles($urandom_range(1, 3));
      xfer(frame_d[0]);
      start = 1'b1;                // stray pulse while loading
      idle_cycles(1);
      start = 1'b0;
      check("d_start_ignored_wc", word_count, 8'd1);
      check("d_start_ignored_busy", {7'd0, busy}, 8'd1);
      idle_cycles($urandom_range(0, 2));
      xfer(frame_d[1]);
      idle_cycles($urandom_range(1, 3));
      xfer(frame_d[2]);
      idle_cycles($urandom_range(0, 3));
      check("d_waiting_in_check", {7'd0, busy}, 8'd1);
      xfer(8'h66);
      check("d_done", {7'd0, done}, 8'd1);
      check("d_wc",   word_count,   8'd3);
      for (int i = 0; i < 3; i++)
         check_mem($sformatf("d_mem%0d", i), 8'(i), frame_d[i]);
      check_mem("d_mem3_kept", 8'd3, 8'hA9);

      // Frame E: N=4, reset after two instruction bytes
      pulse_start();
      xfer(8'd4);
      xfer(8'hA1);
      // Write latency: address 1 shows the old byte until the edge that
      // accepts the new one.
      Read_Address = 8'd1;
      in_valid = 1'b1; in_data = 8'hB2;
      #1;
      check("e_mem1_old", instruction, 8'h22);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("e_mem1_new", instruction, 8'hB2);
      check("e_wc_two", word_count, 8'd2);
      #2 rst_n = 1'b0;
      #1;
      check("e_rst_in_ready", {7'd0, in_ready}, 8'd0);
      check("e_rst_busy",     {7'd0, busy},     8'd0);
      check("e_rst_done",     {7'd0, done},     8'd0);
      check("e_rst_error",    {7'd0, error},    8'd0);
      check("e_rst_wc",       word_count,       8'd0);
      check_mem("e_mem0_kept", 8'd0, 8'hA1);
      check_mem("e_mem1_kept", 8'd1, 8'hB2);
      check_mem("e_mem2_old",  8'd2, 8'h33);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Frame F: carry wrap, FF + 02 = 01 mod 256
      pulse_start();
      xfer(8'd2);
      xfer(8'hFF);
      xfer(8'h02);
      xfer(8'h01);
      check("f_done",  {7'd0, done},  8'd1);
      check("f_error", {7'd0, error}, 8'd0);
      check("f_wc",    word_count,    8'd2);
      check_mem("f_mem0", 8'd0, 8'hFF);
      check_mem("f_mem1", 8'd1, 8'h02);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
